// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the Ethernet transmit arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_STREAM   = 2'd2,
        ST_GAP      = 2'd3
    } arb_state_t;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DEFAULT_IFG = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping to index 0. Reusable by any shared-resource block.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    logic [PW:0] w_cand;

    // Walk candidates ptr, ptr+1, ... modulo N and take the first requester.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_cand >= (PW+1)'(N)) begin
                w_cand = w_cand - (PW+1)'(N);
            end
            if (!o_valid && i_req[w_cand[PW-1:0]]) begin
                o_valid                  = 1'b1;
                o_idx                    = w_cand[PW-1:0];
                o_grant[w_cand[PW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing the MAC transmit byte port between protocol
// reply senders. The grant is held for a whole frame and an inter-frame
// gap is enforced after each completed frame.
// Optional per-requester completed-frame counters: ETH_TX_ARB_STATS_EN.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned IFG_CYCLES = DEFAULT_IFG,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*BYTE_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ack_o,
    output logic [BYTE_W-1:0]       mac_data_o,
    output logic                    mac_valid_o,
    input  logic                    mac_ack_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]  frm_cnt_o
`endif
);

    localparam int unsigned PW       = $clog2(N_REQ);
    localparam int unsigned GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [PW-1:0]    r_gidx;
    logic [PW-1:0]    r_ptr;
    logic [GAP_W-1:0] r_gap;

    logic [N_REQ-1:0] w_pick;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_vld;
    logic             w_gvalid;
    logic             w_in_frame;
    logic             w_frame_done;
    logic [PW-1:0]    w_ptr_next;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    assign w_gvalid     = |(req_valid_i & r_grant);
    assign w_in_frame   = (r_state == ST_WAIT_ACK) || (r_state == ST_STREAM);
    assign w_frame_done = (r_state == ST_STREAM) && !w_gvalid;
    assign w_ptr_next   = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);

    // Zero-latency forwarding from the registered grant.
    always_comb begin
        mac_data_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                mac_data_o = mac_data_o | req_data_i[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign mac_valid_o = w_in_frame & w_gvalid;
    assign req_ack_o   = (r_state == ST_WAIT_ACK) ? (r_grant & {N_REQ{mac_ack_i}}) : '0;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state != ST_IDLE);

    // Frame-level FSM: arbitrate, wait for first-byte ack, stream, gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!w_gvalid) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end else if (mac_ack_i) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (!w_gvalid) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_gap   <= '0;
                        r_state <= (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_W'(GAP_LAST)) begin
                        r_gap   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [CNT_W-1:0] r_frm_cnt [N_REQ];

    // Count completed frames only; aborts leave the counters alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                r_frm_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (w_frame_done && r_grant[k]) begin
                    r_frm_cnt[k] <= r_frm_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        frm_cnt_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            frm_cnt_o[k*CNT_W +: CNT_W] = r_frm_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: a cycle table on an IFG=0 instance
// plus sender/MAC models driving a default IFG=12 instance.
module tb_eth_tx_arbiter;

    localparam int unsigned ACK_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    logic [15:0] req_data_a;
    logic [1:0]  req_valid_a, req_ack_a, grant_a;
    logic [7:0]  mac_data_a;
    logic        mac_valid_a, mac_ack_a, busy_a;
    logic [15:0] req_data_b;
    logic [1:0]  req_valid_b, req_ack_b, grant_b;
    logic [7:0]  mac_data_b;
    logic        mac_valid_b, mac_ack_b, busy_b;
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] frm_cnt_a, frm_cnt_b;
`endif

    eth_tx_arbiter #(.N_REQ(2), .IFG_CYCLES(12), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_a),
        .req_data_i(req_data_a), .req_valid_i(req_valid_a), .req_ack_o(req_ack_a),
        .mac_data_o(mac_data_a), .mac_valid_o(mac_valid_a), .mac_ack_i(mac_ack_a),
        .grant_o(grant_a), .busy_o(busy_a)
`ifdef ETH_TX_ARB_STATS_EN
        , .frm_cnt_o(frm_cnt_a)
`endif
    );

    eth_tx_arbiter #(.N_REQ(2), .IFG_CYCLES(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_b),
        .req_data_i(req_data_b), .req_valid_i(req_valid_b), .req_ack_o(req_ack_b),
        .mac_data_o(mac_data_b), .mac_valid_o(mac_valid_b), .mac_ack_i(mac_ack_b),
        .grant_o(grant_b), .busy_o(busy_b)
`ifdef ETH_TX_ARB_STATS_EN
        , .frm_cnt_o(frm_cnt_b)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sender / MAC / monitor model state for instance A.
    int unsigned left[2], pos[2], flen[2];
    bit          started[2], cool[2], abort_f[2];
    logic [1:0]  obs_ack, obs_grant;
    bit          macd;
    int unsigned mwait, mpos, cur_own, run, bad_ack, byte_err;
    int unsigned ack_cnt[2];
    int unsigned fr_own[$], fr_len[$], gaps[$];

    function automatic logic [7:0] byte_of(input int unsigned k, input int unsigned p);
        return 8'((p * 7 + k * 64 + 1) % 256);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; pos[k] = 0; flen[k] = 0;
            started[k] = 0; cool[k] = 0; abort_f[k] = 0; ack_cnt[k] = 0;
        end
        req_valid_a = '0; req_data_a = '0; mac_ack_a = 1'b0;
        obs_ack = '0; obs_grant = '0; macd = 0;
        mwait = 0; mpos = 0; cur_own = 0; run = 0; bad_ack = 0; byte_err = 0;
        fr_own.delete(); fr_len.delete(); gaps.delete();
    endtask

    // One clock of instance A: senders step, MAC responds, monitor samples.
    task automatic tick();
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if (req_valid_a[k]) begin
                if (!started[k]) begin
                    if (obs_ack[k]) begin
                        started[k] = 1; pos[k] = 1;
                    end else if (abort_f[k] && obs_grant[k]) begin
                        req_valid_a[k] = 1'b0; left[k] = 0; abort_f[k] = 0;
                    end
                end else begin
                    pos[k]++;
                    if (pos[k] == flen[k]) begin
                        req_valid_a[k] = 1'b0; started[k] = 0; pos[k] = 0;
                        left[k]--; cool[k] = 1;
                    end
                end
            end else if (cool[k]) begin
                cool[k] = 0;
            end else if (left[k] > 0) begin
                req_valid_a[k] = 1'b1; pos[k] = 0;
            end
            req_data_a[k*8 +: 8] = byte_of(k, pos[k]);
        end
        #1;
        if (mac_valid_a && !macd) begin
            mwait++;
            mac_ack_a = (mwait == ACK_LAT);
        end else begin
            mwait = 0;
            mac_ack_a = 1'b0;
        end
        @(negedge clk);
        obs_ack   = req_ack_a;
        obs_grant = grant_a;
        if ((req_ack_a & ~grant_a) != 2'b00) bad_ack++;
        for (int k = 0; k < 2; k++) if (req_ack_a[k]) ack_cnt[k]++;
        if (mac_valid_a && (mac_ack_a || macd)) begin
            cur_own = grant_a[1] ? 1 : 0;
            if (mac_data_a !== byte_of(cur_own, mpos)) byte_err++;
            mpos++;
            macd = 1;
        end else if (macd) begin
            fr_own.push_back(cur_own);
            fr_len.push_back(mpos);
            macd = 0; mpos = 0;
        end
        if (busy_a && grant_a == 2'b00) run++;
        else if (run > 0) begin
            gaps.push_back(run); run = 0;
        end
    endtask

    task automatic run_until_quiet(input string name, input int unsigned max_cyc);
        int unsigned n = 0;
        do begin
            tick(); n++;
        end while (((left[0] | left[1]) != 0 || busy_a || req_valid_a != 2'b00) && n < max_cyc);
        check({name, "_done"}, 32'(n < max_cyc), 1);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
    endtask

    function automatic int unsigned q_at(input int unsigned q[$], input int unsigned i);
        return (i < q.size()) ? q[i] : 99;
    endfunction

    typedef struct {
        logic [1:0] vld;
        logic       ack;
        logic [1:0] grant;
        logic       mval;
        logic [1:0] rack;
        logic       busy;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int unsigned n;
        logic [5:0] ord;

        // IFG=0 instance: req0 = A0, req1 = B1.
        tbl[0]  = '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
        tbl[1]  = '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 8'hA0};
        tbl[2]  = '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA0};
        tbl[3]  = '{2'b01, 1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 8'hA0};
        tbl[4]  = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 8'hA0};
        tbl[5]  = '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA0};
        tbl[6]  = '{2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
        tbl[7]  = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 8'hB1};
        tbl[8]  = '{2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 8'hB1};
        tbl[9]  = '{2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 8'hB1};
        tbl[10] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
        tbl[11] = '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA0};
        tbl[12] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
        tbl[13] = '{2'b11, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 8'hB1};

        rst_a = 1'b0; rst_b = 1'b0;
        model_clear();
        req_data_b = 16'hB1A0; req_valid_b = '0; mac_ack_b = 1'b0;
        repeat (2) @(negedge clk);

        // Outputs stay quiet in reset even with requests pending.
        req_valid_a = 2'b11; req_data_a = 16'h5A5A; mac_ack_a = 1'b1;
        #1;
        check("rst_grant", 32'(grant_a), 0);
        check("rst_mvalid", 32'(mac_valid_a), 0);
        check("rst_ack", 32'(req_ack_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_data", 32'(mac_data_a), 0);
        model_clear();
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            req_valid_b = tbl[i].vld;
            mac_ack_b   = tbl[i].ack;
            @(negedge clk);
            check($sformatf("b%0d_grant", i), 32'(grant_b), 32'(tbl[i].grant));
            check($sformatf("b%0d_mvalid", i), 32'(mac_valid_b), 32'(tbl[i].mval));
            check($sformatf("b%0d_ack", i), 32'(req_ack_b), 32'(tbl[i].rack));
            check($sformatf("b%0d_busy", i), 32'(busy_b), 32'(tbl[i].busy));
            check($sformatf("b%0d_data", i), 32'(mac_data_b), 32'(tbl[i].data));
        end
        @(posedge clk); #1;
        req_valid_b = '0; mac_ack_b = 1'b0;

        // Single 42-byte frame from req0.
        reset_a();
        flen[0] = 42; left[0] = 1;
        run_until_quiet("s1", 400);
        check("s1_nframes", fr_own.size(), 1);
        check("s1_owner", q_at(fr_own, 0), 0);
        check("s1_len", q_at(fr_len, 0), 42);
        check("s1_bytes", byte_err, 0);
        check("s1_ack0", ack_cnt[0], 1);
        check("s1_ack1", ack_cnt[1], 0);
        check("s1_gap", q_at(gaps, 0), 12);
        check("s1_grant_end", 32'(grant_a), 0);

        // Simultaneous requests from pointer 0.
        reset_a();
        flen[0] = 10; flen[1] = 10; left[0] = 1; left[1] = 1;
        run_until_quiet("s2", 400);
        check("s2_first", q_at(fr_own, 0), 0);
        check("s2_second", q_at(fr_own, 1), 1);
        check("s2_gap", q_at(gaps, 0), 12);
        check("s2_bad_ack", bad_ack, 0);
        check("s2_ack1", ack_cnt[1], 1);
        check("s2_bytes", byte_err, 0);

        // Continuous round-robin over six frames.
        reset_a();
        flen[0] = 8; flen[1] = 8; left[0] = 3; left[1] = 3;
        run_until_quiet("s3", 600);
        ord = '0;
        for (int i = 0; i < 6; i++) ord[i] = (q_at(fr_own, i) == 1);
        check("s3_nframes", fr_own.size(), 6);
        check("s3_order", 32'(ord), 32'h2A);
        check("s3_bad_ack", bad_ack, 0);
        check("s3_bytes", byte_err, 0);
`ifdef ETH_TX_ARB_STATS_EN
        check("s3_frm_cnt", frm_cnt_a, {16'd3, 16'd3});
`endif

        // req1 aborts before ack.
        reset_a();
        abort_f[1] = 1; flen[1] = 10; left[1] = 1;
        run_until_quiet("s4", 100);
        check("s4_nframes", fr_own.size(), 0);
        check("s4_no_gap", gaps.size(), 0);
        check("s4_ack1", ack_cnt[1], 0);
`ifdef ETH_TX_ARB_STATS_EN
        check("s4_frm_cnt", frm_cnt_a, 0);
`endif
        flen[0] = 6; flen[1] = 6; left[0] = 1; left[1] = 1;
        run_until_quiet("s4b", 300);
        check("s4_ptr_first", q_at(fr_own, 0), 0);
        check("s4_ptr_second", q_at(fr_own, 1), 1);

        // Reset during the 20th byte of a second frame (pointer = 1).
        reset_a();
        flen[0] = 42; left[0] = 2;
        n = 0;
        while (!(fr_own.size() == 1 && mpos == 20) && n < 500) begin
            tick(); n++;
        end
        check("s5_reach", 32'(n < 500), 1);
        check("s5_mid_valid", 32'(mac_valid_a), 1);
        #2 rst_a = 1'b0;
        #1;
        check("s5_rst_valid", 32'(mac_valid_a), 0);
        check("s5_rst_ack", 32'(req_ack_a), 0);
        check("s5_rst_grant", 32'(grant_a), 0);
        check("s5_rst_busy", 32'(busy_a), 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        tick();
        check("s5_rel_busy", 32'(busy_a), 0);
        flen[0] = 6; flen[1] = 6; left[0] = 1; left[1] = 1;
        run_until_quiet("s5b", 300);
        check("s5_ptr_first", q_at(fr_own, 0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet MAC transmit byte port between N_REQ protocol reply senders (ARP, ICMP, ...).
- Each sender uses the codebase's MAC-side handshake:
  - valid rises with byte 0;
  - the MAC's ack accepts byte 0;
  - the sender then streams one byte per cycle with valid high;
  - valid drops after the last byte.
- The arbiter picks one requester round-robin, forwards its stream unchanged and holds the grant for the whole frame.
- It enforces an inter-frame gap before the next grant.
- It sits between the eth_proto_sender instances and the MAC.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- IFG_CYCLES, 12, idle cycles forced after each completed frame (0 allowed).
- CNT_W, 16, width of each optional frame counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_data_i  input  N_REQ*8  requester bytes; requester k occupies bits [8k+7:8k].
- req_valid_i  input  N_REQ  requester frame-valid.
- req_ack_o  output  N_REQ  ack routed to the granted requester only.
- mac_data_o  output  8  byte to the MAC.
- mac_valid_o  output  1  valid to the MAC.
- mac_ack_i  input  1  first-byte ack from the MAC.
- grant_o  output  N_REQ  one-hot current grant; all zeros when none.
- busy_o  output  1  high in any state other than ST_IDLE.
- frm_cnt_o  output  N_REQ*CNT_W  completed-frame counters (present only with the optional feature).

Behaviour:
- Reset: clk and rst_n, asynchronous active-low. While rst_n is low, and on its release:
  - state = ST_IDLE;
  - grant register = 0;
  - round-robin pointer = 0;
  - gap counter = 0;
  - all outputs = 0.
- Datapath is combinational from the registered grant:
  - mac_data_o = granted req_data_i byte (0 if no grant);
  - mac_valid_o = granted req_valid_i while in ST_WAIT_ACK or ST_STREAM, else 0;
  - req_ack_o[g] = mac_ack_i while in ST_WAIT_ACK; all other bits are 0 at all times.
- Zero added latency on the data, valid and ack paths. This is mandatory because the sender advances every cycle after the ack.
- ST_IDLE:
  - If any req_valid_i bit is high, select the first set bit, searching from the pointer upward with wrap-around.
  - Register the grant and go to ST_WAIT_ACK. Arbitration costs 1 cycle.
  - mac_valid_o is 0 in ST_IDLE.
- ST_WAIT_ACK:
  - On mac_ack_i with granted valid high, go to ST_STREAM.
  - If granted valid falls before any ack (abort), go to ST_IDLE with no gap. Clear the grant and set pointer = g+1 mod N_REQ.
- ST_STREAM:
  - Forward bytes every cycle.
  - On the first cycle granted valid is low (end of frame): clear the grant, set pointer = g+1 mod N_REQ, and increment frm_cnt[g] (optional feature).
  - Go to ST_GAP, or to ST_IDLE when IFG_CYCLES = 0.
- ST_GAP:
  - Count IFG_CYCLES cycles with mac_valid_o = 0 and all acks = 0, then go to ST_IDLE.
  - Requests arriving during the gap wait; their valid stays high per the sender protocol.
- A mac_ack_i pulse in ST_STREAM, ST_GAP or ST_IDLE is ignored and is not forwarded.
- Non-granted requesters are never acked. They keep valid high and are not disturbed.
- Simultaneous requests: the round-robin order guarantees each waiting requester a grant within N_REQ frames.
- Pointer wrap-around: pointer = N_REQ-1 wraps the search to 0.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous) and the frame is truncated. Requesters are reset by the same rst_n.
- Frame length is unbounded. The arbiter only tracks valid.

Optional Feature:
- Macro: ETH_TX_ARB_STATS_EN.
- Defined:
  - frm_cnt_o is present, one CNT_W counter per requester;
  - each counter increments on completed frames only (not aborts);
  - counters wrap at 2^CNT_W-1 to 0;
  - counters reset to 0.
- Not defined: the port and counters are absent, and all other behaviour is identical.

Decomposition:
- Package eth_tx_arb_pkg:
  - state enum (ST_IDLE, ST_WAIT_ACK, ST_STREAM, ST_GAP);
  - byte width constant (8);
  - default IFG constant.
- Sub-module rr_arbiter: a combinational round-robin pick (req vector + pointer -> one-hot grant + index). Reusable by other shared-resource blocks.

Test Plan:
- Single requester: req0 sends a 42-byte ARP reply, MAC ack in cycle 3 after valid rises.
  - MAC sees 42 bytes in order with no gaps.
  - req_ack_o = 01 for exactly 1 cycle.
  - grant_o returns to 00 and ST_GAP lasts 12 cycles.
- Simultaneous requests, with req0 and req1 valid on the same cycle and pointer 0:
  - req0 frame sent first, 12-cycle gap, then req1 frame;
  - req1 never receives an ack during req0's frame.
- Round-robin: both requesters send continuously for 6 frames.
  - Grant order is 0,1,0,1,0,1.
  - With the stats feature on, frm_cnt = 3/3.
- Abort: req1 drops valid in ST_WAIT_ACK before any ack.
  - Return to ST_IDLE with no gap.
  - Pointer = 0; the counter is not incremented.
- Reset mid-stream: rst_n is asserted at byte 20 of 42.
  - mac_valid_o, req_ack_o and grant_o are 0 the same cycle.
  - After release: ST_IDLE with pointer 0.
- IFG_CYCLES = 0 with a stray mac_ack_i during ST_STREAM:
  - back-to-back frames have exactly 1 idle arbitration cycle between them;
  - the stray ack is not forwarded.
